// File: rtl/wb_bist_arb.sv
// Two-master Wishbone arbiter: host (m0) and BIST engine (m1) share one slave.
// Round-robin on ties, one transfer per grant, and a per-grant response
// timeout that errors the stalled master and latches a sticky flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; s_cyc_o/s_stb_o low; arbitrate pending requests
// GNT0  | host master owns the slave port for one transfer
// GNT1  | BIST master owns the slave port for one transfer
module wb_bist_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255
) (
  input  logic            mclk,
  input  logic            rst_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic            tmo_sticky_o,
  input  logic            tmo_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);

  state_t          state, state_nxt;
  logic            last_gnt, last_gnt_nxt;
  logic [7:0]      tmo_cnt;
  logic            tmo_fire;
  logic            tmo_sticky;
  logic            req0, req1, resp, gnt, gnt1;
  logic            g_cyc, g_stb, g_we;
  logic [AW-1:0]   g_adr;
  logic [DW-1:0]   g_dat;
  logic [DW/8-1:0] g_sel;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign resp = s_ack_i | s_err_i;
  assign gnt  = (state != IDLE);
  assign gnt1 = (state == GNT1);

  // Select the request fields of whichever master the state says owns the port
  always_comb begin
    g_cyc = gnt1 ? m1_cyc_i : m0_cyc_i;
    g_stb = gnt1 ? m1_stb_i : m0_stb_i;
    g_we  = gnt1 ? m1_we_i  : m0_we_i;
    g_adr = gnt1 ? m1_adr_i : m0_adr_i;
    g_dat = gnt1 ? m1_dat_i : m0_dat_i;
    g_sel = gnt1 ? m1_sel_i : m0_sel_i;
  end

  // Arbitration, slave-port steering, response routing and timeout detection
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    tmo_fire     = 1'b0;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_adr_o      = '0;
    s_dat_o      = '0;
    s_sel_o      = '0;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    case (state)
      IDLE: begin
        // last_gnt==1 means m1 was served last, so m0 wins a tie
        if (req0 && (!req1 || last_gnt)) state_nxt = GNT0;
        else if (req1)                   state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        // A real response beats the timeout; an abandoned cycle is not errored
        tmo_fire = g_cyc && !resp && (tmo_cnt == TMO_LIM);
        s_cyc_o  = g_cyc && !tmo_fire;
        s_stb_o  = g_stb && !tmo_fire;
        s_we_o   = g_we;
        s_adr_o  = g_adr;
        s_dat_o  = g_dat;
        s_sel_o  = g_sel;
        if (gnt1) begin
          m1_ack_o = s_ack_i;
          m1_err_o = s_err_i || tmo_fire;
        end else begin
          m0_ack_o = s_ack_i;
          m0_err_o = s_err_i || tmo_fire;
        end
        if (resp || !g_cyc || tmo_fire) begin
          state_nxt    = IDLE;
          last_gnt_nxt = gnt1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer and per-grant wait counter (zeroed while idle)
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      tmo_cnt  <= 8'd0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      tmo_cnt  <= gnt ? tmo_cnt + 8'd1 : 8'd0;
    end
  end

  // Sticky timeout flag; a new timeout outranks a clear in the same cycle
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n)         tmo_sticky <= 1'b0;
    else if (tmo_fire)  tmo_sticky <= 1'b1;
    else if (tmo_clr_i) tmo_sticky <= 1'b0;
  end

  assign tmo_sticky_o = tmo_sticky;
  assign m0_dat_o     = s_dat_i;
  assign m1_dat_o     = s_dat_i;

endmodule
